fir_bank_scheduler: RTL and testbench

Sequencer for the 8-channel polyphase FIR bank. It accepts input samples from the ADC front end and holds one pending sample. It issues each sample to the bank with a single enable strobe, waits out the bank's fixed computation window, and captures the eight channel results. It then serialises them onto one valid/ready output stream. It sits between the sample source and the FIR bank, and between the FIR bank and the downstream packer, and is the only block that drives the bank's `din_enable`.

---
 rtl/fir_bank_pkg.sv | 10 +
 rtl/fir_out_serializer.sv | 41 ++++
 rtl/fir_bank_scheduler.sv | 82 ++++++++
 tb/tb_fir_bank_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_bank_pkg.sv
// fir_bank_pkg: shared constants, state encoding and channel slice helper for the FIR bank scheduler
package fir_bank_pkg;
  localparam int FIR_LATENCY_DEFAULT = 68;
  localparam int NCH = 8;
  localparam int DW = 16;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DRAIN} state_t;
  function automatic logic [DW-1:0] ch_slice(input logic [NCH*DW-1:0] bus, input logic [2:0] n);
    return bus[n*DW +: DW];
  endfunction
endpackage

// File: rtl/fir_out_serializer.sv
// fir_out_serializer: captures all bank channels and streams them out in order over valid/ready
module fir_out_serializer
  import fir_bank_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic [NCH*DW-1:0] bank_in,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        out_channel,
  output logic              out_valid,
  output logic              done
);
  logic [DW-1:0] bank [NCH];
  logic [2:0] idx, idx_nxt;
  logic hs;
  assign hs = out_valid && out_ready;
  assign done = hs && idx == 3'(NCH-1);
  assign idx_nxt = idx + 3'd1;
  assign out_channel = idx;
  // snapshot of every channel result taken in the capture cycle
  always_ff @(posedge clock)
    if (capture)
      for (int i = 0; i < NCH; i++) bank[i] <= ch_slice(bank_in, 3'(i));
  // output stage: channel 0 straight from the bus, later channels from the snapshot
  always_ff @(posedge clock)
    if (!reset) begin
      idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (capture) begin
      idx <= '0;
      out_valid <= 1'b1;
      out_data <= ch_slice(bank_in, 3'd0);
    end else if (hs) begin
      idx <= idx_nxt;
      out_valid <= !done;
      out_data <= done ? '0 : bank[idx_nxt];
    end
endmodule

// File: rtl/fir_bank_scheduler.sv
// fir_bank_scheduler: holds one sample, strobes it into the FIR bank, waits the bank latency, then serialises results
module fir_bank_scheduler
  import fir_bank_pkg::*;
#(
  parameter int FIR_LATENCY = FIR_LATENCY_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DW-1:0]     sample_in,
  input  logic              sample_valid,
  output logic [DW-1:0]     fir_datain,
  output logic              fir_din_enable,
  input  logic [NCH*DW-1:0] fir_dataout,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        out_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clear,
  output logic [7:0]        drop_count
);
  localparam int CW = $clog2(FIR_LATENCY);
  state_t state, state_nxt;
  logic hold_full, accept, drop, done;
  logic [DW-1:0] hold_data;
  logic [CW-1:0] cnt;
  assign accept = sample_valid && (!hold_full || state == ISSUE);
  assign drop = sample_valid && !accept;
  // state register
  always_ff @(posedge clock)
    state <= !reset ? IDLE : state_nxt;
  // next-state selection
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = hold_full ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = cnt == '0 ? CAPTURE : WAIT;
      CAPTURE: state_nxt = DRAIN;
      DRAIN:   state_nxt = done ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // hold register, wait counter and registered bank-side outputs
  always_ff @(posedge clock)
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      cnt <= '0;
      fir_datain <= '0;
      fir_din_enable <= 1'b0;
      busy <= 1'b0;
    end else begin
      hold_full <= accept || (hold_full && state != ISSUE);
      if (accept) hold_data <= sample_in;
      cnt <= state == ISSUE ? CW'(FIR_LATENCY-1) : cnt != '0 ? cnt - 1'b1 : cnt;
      fir_din_enable <= state_nxt == ISSUE;
      if (state_nxt == ISSUE) fir_datain <= hold_data;
      busy <= state_nxt != IDLE;
    end
  // sticky overrun flag and saturating drop counter; clear wins over a same-cycle drop
  always_ff @(posedge clock)
    if (!reset || overrun_clear) begin
      overrun <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      drop_count <= drop_count == 8'hFF ? drop_count : drop_count + 8'd1;
    end
  fir_out_serializer u_ser (
    .clock      (clock),
    .reset      (reset),
    .capture    (state == CAPTURE),
    .bank_in    (fir_dataout),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_channel(out_channel),
    .out_valid  (out_valid),
    .done       (done)
  );
endmodule

// File: tb/tb_fir_bank_scheduler.sv
// tb_fir_bank_scheduler: directed tables and sequences plus randomized traffic checked against a transaction-level model
module tb_fir_bank_scheduler;
  localparam int L = 68;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [15:0] sample_in = '0;
  logic sample_valid = 1'b0;
  logic [15:0] fir_datain;
  logic fir_din_enable;
  logic [127:0] fir_dataout;
  logic [15:0] out_data;
  logic [2:0] out_channel;
  logic out_valid;
  logic out_ready = 1'b1;
  logic busy;
  logic overrun;
  logic overrun_clear = 1'b0;
  logic [7:0] drop_count;

  fir_bank_scheduler #(.FIR_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .fir_datain(fir_datain), .fir_din_enable(fir_din_enable), .fir_dataout(fir_dataout),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .overrun_clear(overrun_clear), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // FIR bank stand-in: latches the strobed sample, results are a fixed function of it
  bit bank_fixed = 1'b1;
  logic [15:0] bank_sample = '0;
  function automatic logic [15:0] bank_ch(input bit fixed, input logic [15:0] s, input int n);
    return fixed ? 16'(16'h0100 + n) : 16'(s * (2*n + 1));
  endfunction
  always @(posedge clock) if (fir_din_enable) bank_sample <= fir_datain;
  always_comb begin
    fir_dataout = '0;
    for (int n = 0; n < 8; n++) fir_dataout[n*16 +: 16] = bank_ch(bank_fixed, bank_sample, n);
  end

  // transaction-level reference: one pending slot, a countdown to results, a count of channels left to hand over
  int edge_n = 0;
  bit m_iss = 0, m_hv = 0, m_ov = 0;
  logic [15:0] m_hd = '0, m_cur = '0;
  int m_cd = 0, m_left = 0, m_drops = 0;
  always @(posedge clock) begin
    bit idle, acc, drp, nis;
    edge_n++;
    if (!reset) begin
      m_iss = 0; m_hv = 0; m_ov = 0; m_hd = '0; m_cur = '0; m_cd = 0; m_left = 0; m_drops = 0;
    end else begin
      idle = !(m_iss || m_cd > 0 || m_left > 0);
      acc = sample_valid && (!m_hv || m_iss);
      drp = sample_valid && !acc;
      nis = idle && m_hv;
      if (m_left > 0 && out_ready) m_left--;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) m_left = 8;
      end
      if (nis) begin
        m_cur = m_hd;
        m_cd = L + 2;
      end
      m_hv = acc || (m_hv && !m_iss);
      if (acc) m_hd = sample_in;
      m_iss = nis;
      if (overrun_clear) begin
        m_ov = 0; m_drops = 0;
      end else if (drp) begin
        m_ov = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  end

  // per-cycle comparison against the model, stall stability, and handshake log
  bit chk_en = 0;
  bit p_v = 0, p_r = 0, p_rs = 0;
  logic [2:0] p_ch = '0;
  logic [15:0] p_d = '0;
  int hs_q[$];
  int en_cnt = 0;
  always @(negedge clock) if (chk_en) begin
    chk("m_enable", 32'(fir_din_enable), 32'(m_iss));
    chk("m_datain", 32'(fir_datain), 32'(m_cur));
    chk("m_valid", 32'(out_valid), 32'(m_left > 0));
    if (m_left > 0) begin
      chk("m_channel", 32'(out_channel), 32'(8 - m_left));
      chk("m_data", 32'(out_data), 32'(bank_ch(bank_fixed, m_cur, 8 - m_left)));
    end
    chk("m_busy", 32'(busy), 32'(m_iss || m_cd > 0 || m_left > 0));
    chk("m_overrun", 32'(overrun), 32'(m_ov));
    chk("m_drops", 32'(drop_count), 32'(m_drops));
    if (p_v && !p_r && p_rs) begin
      chk("stall_channel", 32'(out_channel), 32'(p_ch));
      chk("stall_data", 32'(out_data), 32'(p_d));
    end
    if (out_valid && out_ready) hs_q.push_back(int'(out_channel));
    if (fir_din_enable) en_cnt++;
    p_v = out_valid; p_r = out_ready; p_rs = reset; p_ch = out_channel; p_d = out_data;
  end

  int rmode = 1;
  int rp = 0;
  task automatic cyc();
    @(posedge clock);
    #1;
    rp++;
    out_ready = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : rmode == 2 ? (rp % 3 == 2) : 1'($urandom);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      cyc();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic sv;
    logic [15:0] sin;
    logic clr;
    logic ov;
    logic [7:0] dc;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 16'h2222, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 16'h3333, 1'b0, 1'b1, 8'd1};
    tbl[2] = '{1'b1, 16'h4444, 1'b0, 1'b1, 8'd2};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'd2};
    tbl[4] = '{1'b1, 16'h5555, 1'b1, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 16'h6666, 1'b0, 1'b1, 8'd1};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'd0};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};

    cyc();
    chk_en = 1;
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_enable", 32'(fir_din_enable), 0);
    chk("rst_drops", 32'(drop_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset = 1'b1;
    while (edge_n < 9) cyc();

    sample_valid = 1'b1; sample_in = 16'h1234;
    cyc();
    sample_valid = 1'b0;
    for (int t = 1; t <= 79; t++) begin
      cyc();
      chk("ss_enable", 32'(fir_din_enable), 32'(t == 1));
      if (t == 1) chk("ss_datain", 32'(fir_datain), 32'h1234);
      chk("ss_valid", 32'(out_valid), 32'(t >= 71 && t <= 78));
      if (t >= 71 && t <= 78) begin
        chk("ss_channel", 32'(out_channel), 32'(t - 71));
        chk("ss_data", 32'(out_data), 32'(16'h0100 + t - 71));
      end
      if (t >= 78) chk("ss_busy", 32'(busy), 32'(t == 78));
    end

    bank_fixed = 1'b0;
    rmode = 2;
    hs_q.delete();
    sample_valid = 1'b1; sample_in = 16'h0A5A;
    cyc();
    sample_valid = 1'b0;
    cyc();
    wait_idle(400);
    chk("bp_count", 32'(hs_q.size()), 8);
    for (int i = 0; i < 8; i++) if (i < hs_q.size()) chk("bp_order", 32'(hs_q[i]), 32'(i));

    rmode = 1;
    sample_valid = 1'b1; sample_in = 16'h1111;
    cyc();
    sample_valid = 1'b0;
    repeat (5) cyc();
    for (int i = 0; i < 8; i++) begin
      sample_valid = tbl[i].sv; sample_in = tbl[i].sin; overrun_clear = tbl[i].clr;
      cyc();
      chk("tbl_overrun", 32'(overrun), 32'(tbl[i].ov));
      chk("tbl_drops", 32'(drop_count), 32'(tbl[i].dc));
      chk("tbl_busy", 32'(busy), 1);
    end
    sample_valid = 1'b0; overrun_clear = 1'b0;
    wait_idle(200);
    chk("held_not_yet", 32'(fir_din_enable), 0);
    cyc();
    chk("held_enable", 32'(fir_din_enable), 1);
    chk("held_datain", 32'(fir_datain), 32'h2222);

    sample_valid = 1'b1; sample_in = 16'hBEEF;
    cyc();
    sample_valid = 1'b0;
    chk("issue_acc_overrun", 32'(overrun), 0);
    chk("issue_acc_drops", 32'(drop_count), 0);
    repeat (3) cyc();
    sample_valid = 1'b1; sample_in = 16'hAAAA;
    cyc();
    sample_in = 16'hBBBB;
    cyc();
    sample_valid = 1'b0;
    chk("wait_drop_overrun", 32'(overrun), 1);
    chk("wait_drop_count", 32'(drop_count), 2);
    wait_idle(200);
    cyc();
    chk("beef_enable", 32'(fir_din_enable), 1);
    chk("beef_datain", 32'(fir_datain), 32'hBEEF);

    repeat (3) cyc();
    sample_valid = 1'b1; sample_in = 16'hCCCC;
    cyc();
    sample_valid = 1'b0;
    begin
      int n = 0;
      while (!(out_valid && out_channel == 3'd4) && n < 200) begin
        cyc();
        n++;
      end
      chk("ch4_reached", 32'(out_valid && out_channel == 3'd4), 1);
    end
    rmode = 0; out_ready = 1'b0; reset = 1'b0;
    hs_q.delete();
    en_cnt = 0;
    cyc();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_channel", 32'(out_channel), 0);
    chk("mid_rst_enable", 32'(fir_din_enable), 0);
    chk("mid_rst_datain", 32'(fir_datain), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_drops", 32'(drop_count), 0);
    reset = 1'b1; rmode = 1; out_ready = 1'b1;
    repeat (100) cyc();
    chk("post_rst_outputs", 32'(hs_q.size()), 0);
    chk("post_rst_issues", 32'(en_cnt), 0);

    sample_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      sample_in = 16'($urandom);
      cyc();
    end
    sample_valid = 1'b0;
    chk("sat_drops", 32'(drop_count), 255);
    chk("sat_overrun", 32'(overrun), 1);
    overrun_clear = 1'b1;
    cyc();
    overrun_clear = 1'b0;
    chk("sat_clear_drops", 32'(drop_count), 0);
    chk("sat_clear_overrun", 32'(overrun), 0);

    rmode = 3;
    for (int i = 0; i < 3000; i++) begin
      sample_valid = $urandom_range(0, 5) == 0;
      sample_in = 16'($urandom);
      overrun_clear = $urandom_range(0, 199) == 0;
      reset = !($urandom_range(0, 1499) == 0);
      cyc();
    end
    sample_valid = 1'b0; overrun_clear = 1'b0; reset = 1'b1; rmode = 1;
    repeat (250) cyc();
    chk("final_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
